// File: rtl/complex_row_packer.sv
// rtl/complex_row_packer.sv - double-buffered row packer feeding the 8-way complex dot-product unit
//
// Accepts one complex operand pair (in_a, in_b) per cycle and packs N pairs into two
// EW*N-bit rows. Two banks: one fills while the other is presented to the unit.
// Element k (k = 0 first accepted) lands in bits [EW*(N-k)-1 : EW*(N-k-1)].
//
// Optional feature: ROW_PACKER_ZERO_PAD_EN adds in_last, which closes a bank early
// and zero-fills the remaining slots.
//
// Ports:
//   clk               clock, rising edge
//   reset             asynchronous active-low reset
//   in_valid/in_ready input pair handshake (in_ready depends on bank state only)
//   in_a, in_b        element for row A / row B
//   in_last           end of vector (ROW_PACKER_ZERO_PAD_EN only)
//   first_row_input   presented row A
//   second_row_input  presented row B
//   outsider_read_now rows valid, unit may start
//   finish            unit done with presented rows
//   rows_done         count of released rows, wraps at 2^16
module complex_row_packer #(
    parameter int EW = 64,
    parameter int N  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EW-1:0]   in_a,
    input  logic [EW-1:0]   in_b,
`ifdef ROW_PACKER_ZERO_PAD_EN
    input  logic            in_last,
`endif
    output logic [EW*N-1:0] first_row_input,
    output logic [EW*N-1:0] second_row_input,
    output logic            outsider_read_now,
    input  logic            finish,
    output logic [15:0]     rows_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = EW * N;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_e;

    typedef enum logic {
        PRES_IDLE,
        PRES_ACTIVE
    } pres_state_e;

    bank_state_e       bank_state_q [2];
    bank_state_e       bank_state_d [2];
    logic [RW-1:0]     bank_a_q     [2];
    logic [RW-1:0]     bank_a_d     [2];
    logic [RW-1:0]     bank_b_q     [2];
    logic [RW-1:0]     bank_b_d     [2];
    logic              fill_ptr_q, fill_ptr_d;
    logic [IW-1:0]     fill_idx_q, fill_idx_d;
    pres_state_e       pres_q, pres_d;
    logic              pres_ptr_q, pres_ptr_d;
    logic [RW-1:0]     row_a_q, row_a_d;
    logic [RW-1:0]     row_b_q, row_b_d;
    logic [15:0]       rows_done_q, rows_done_d;

    logic accept;
    logic close_row;

    assign in_ready = (bank_state_q[fill_ptr_q] != BANK_FULL);
    assign accept   = in_valid && in_ready;

`ifdef ROW_PACKER_ZERO_PAD_EN
    assign close_row = (fill_idx_q == IW'(N - 1)) || in_last;
`else
    assign close_row = (fill_idx_q == IW'(N - 1));
`endif

    assign first_row_input   = row_a_q;
    assign second_row_input  = row_b_q;
    assign outsider_read_now = (pres_q == PRES_ACTIVE);
    assign rows_done         = rows_done_q;

    always_comb begin
        bank_state_d = bank_state_q;
        bank_a_d     = bank_a_q;
        bank_b_d     = bank_b_q;
        fill_ptr_d   = fill_ptr_q;
        fill_idx_d   = fill_idx_q;
        pres_d       = pres_q;
        pres_ptr_d   = pres_ptr_q;
        row_a_d      = row_a_q;
        row_b_d      = row_b_q;
        rows_done_d  = rows_done_q;

        // Present side. pres_ptr follows fill order, so banks are shown strictly in turn.
        case (pres_q)
            PRES_IDLE: begin
                if (bank_state_q[pres_ptr_q] == BANK_FULL) begin
                    row_a_d = bank_a_q[pres_ptr_q];
                    row_b_d = bank_b_q[pres_ptr_q];
                    pres_d  = PRES_ACTIVE;
                end
            end
            PRES_ACTIVE: begin
                if (finish) begin
                    bank_state_d[pres_ptr_q] = BANK_EMPTY;
                    rows_done_d              = rows_done_q + 16'd1;
                    pres_ptr_d               = ~pres_ptr_q;
                    pres_d                   = PRES_IDLE;
                end
            end
            default: pres_d = PRES_IDLE;
        endcase

        // Fill side. The bank released above is FULL, so in_ready already excluded it;
        // fill and release never target the same bank on one edge.
        if (accept) begin
            // Clearing on the first slot leaves zeros behind an early close.
            if (fill_idx_q == '0) begin
                bank_a_d[fill_ptr_q] = '0;
                bank_b_d[fill_ptr_q] = '0;
            end
            for (int s = 0; s < N; s++) begin
                if (fill_idx_q == IW'(s)) begin
                    bank_a_d[fill_ptr_q][EW*(N-s)-1 -: EW] = in_a;
                    bank_b_d[fill_ptr_q][EW*(N-s)-1 -: EW] = in_b;
                end
            end
            if (close_row) begin
                bank_state_d[fill_ptr_q] = BANK_FULL;
                fill_idx_d               = '0;
                fill_ptr_d               = ~fill_ptr_q;
            end else begin
                bank_state_d[fill_ptr_q] = BANK_FILLING;
                fill_idx_d               = fill_idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                bank_state_q[i] <= BANK_EMPTY;
                bank_a_q[i]     <= '0;
                bank_b_q[i]     <= '0;
            end
            fill_ptr_q  <= 1'b0;
            fill_idx_q  <= '0;
            pres_q      <= PRES_IDLE;
            pres_ptr_q  <= 1'b0;
            row_a_q     <= '0;
            row_b_q     <= '0;
            rows_done_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                bank_state_q[i] <= bank_state_d[i];
                bank_a_q[i]     <= bank_a_d[i];
                bank_b_q[i]     <= bank_b_d[i];
            end
            fill_ptr_q  <= fill_ptr_d;
            fill_idx_q  <= fill_idx_d;
            pres_q      <= pres_d;
            pres_ptr_q  <= pres_ptr_d;
            row_a_q     <= row_a_d;
            row_b_q     <= row_b_d;
            rows_done_q <= rows_done_d;
        end
    end

endmodule
